// File: rtl/dct_transpose_buf_if.sv
// Handshake bundle between the row DCT pass, the transpose buffer and DCT_second.
// The buffer takes the slave view; the row producer / column consumer side takes master.
interface dct_transpose_buf_if #(
  parameter int W = 9
);
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] in_row;
  logic           out_valid;
  logic           out_ready;
  logic [8*W-1:0] out_col;
  logic [2:0]     out_idx;
  logic           out_last;

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_col, out_idx, out_last
  );

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_col, out_idx, out_last
  );
endinterface

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows fill one bank while the other bank
// drains column by column, with the column index feeding DCT_second's count1.
module dct_transpose_buf #(
  parameter int W = 9
) (
  input  logic               clk,
  input  logic               rst,
  dct_transpose_buf_if.slave bus
);

  logic [W-1:0]   mem_q [2][8][8];
  logic [1:0]     full_q, full_d;
  logic           wr_bank_q, wr_bank_d;
  logic [2:0]     wr_row_q, wr_row_d;
  logic           rd_bank_q, rd_bank_d;
  logic [2:0]     rd_col_q, rd_col_d;
  logic           in_ready, out_valid;
  logic           wr_fire, rd_fire;
  logic [8*W-1:0] col;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = bus.in_valid & in_ready;
  assign rd_fire   = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = rd_col_q;
  assign bus.out_last  = out_valid & (rd_col_q == 3'd7);
  assign bus.out_col   = col;

  // Writer only fills a bank whose flag is clear and reader only drains a set one,
  // so a set and a clear never hit the same bank in one cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    if (wr_fire) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_fire) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all of them update together.
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= 3'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
    end
  end

  // NOTE: bank storage is deliberately not reset; full flags gate every read, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < 8; c++) begin
        mem_q[wr_bank_q][wr_row_q][c] <= bus.in_row[8*W-1-W*c -: W];
      end
    end
  end

  // Column read is a plain mux; forced to zero while nothing is being offered.
  always_comb begin
    col = '0;
    if (out_valid) begin
      for (int r = 0; r < 8; r++) begin
        col[8*W-1-W*r -: W] = mem_q[rd_bank_q][r][rd_col_q];
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Self-checking bench for dct_transpose_buf: a queue of expected columns models
// the buffer as "completed blocks waiting to be read, at most two at a time".
module tb_dct_transpose_buf;
  localparam int W  = 9;
  localparam int RW = 8 * W;
  localparam int VW = RW + 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct_transpose_buf_if #(.W(W)) bus ();
  dct_transpose_buf #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: transposed columns of completed blocks plus the block being filled.
  logic [RW-1:0] col_q[$];
  logic [RW-1:0] part [8];
  int            part_n = 0;

  function automatic int pending();
    return (col_q.size() + 7) / 8;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    int            n;
    logic          v;
    logic [2:0]    idx;
    logic [RW-1:0] c;
    n   = col_q.size();
    v   = (n > 0);
    idx = 3'((8 - n % 8) % 8);
    c   = v ? col_q[0] : '0;
    return {pending() < 2, v, idx, v && (idx == 3'd7), c};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last, bus.out_col};
  endfunction

  function automatic void model_reset();
    col_q.delete();
    part_n = 0;
  endfunction

  function automatic void model_push_row(input logic [RW-1:0] row);
    logic [RW-1:0] c;
    part[part_n] = row;
    part_n++;
    if (part_n == 8) begin
      for (int cc = 0; cc < 8; cc++) begin
        for (int r = 0; r < 8; r++) c[RW-1-W*r -: W] = part[r][RW-1-W*cc -: W];
        col_q.push_back(c);
      end
      part_n = 0;
    end
  endfunction

  // kind 0: 8r+c, kind 1: -(8r+c), otherwise random
  function automatic logic [RW-1:0] make_row(input int r, input int kind);
    logic [RW-1:0] row;
    logic [W-1:0]  e;
    for (int c = 0; c < 8; c++) begin
      case (kind)
        0:       e = W'(8 * r + c);
        1:       e = W'(-(8 * r + c));
        default: e = W'($urandom);
      endcase
      row[RW-1-W*c -: W] = e;
    end
    return row;
  endfunction

  // Advance one clock; model consumes the handshakes the spec says occur this cycle.
  task automatic tick();
    logic          wf, rf, rs;
    logic [RW-1:0] row;
    wf  = bus.in_valid && (pending() < 2);
    rf  = bus.out_ready && (col_q.size() > 0);
    rs  = rst;
    row = bus.in_row;
    @(posedge clk);
    if (rs) model_reset();
    else begin
      if (rf) void'(col_q.pop_front());
      if (wf) model_push_row(row);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_row = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (obs_vec() !== {1'b1, 1'b0, 3'd0, 1'b0, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), {1'b1, 5'd0, {RW{1'b0}}});
    end
  endtask

  task automatic test_single_block(input int kind, input string name);
    logic [RW-1:0] exp;
    int n;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bus.in_valid = 1'b1;
      bus.in_row = make_row(r, kind);
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL %s_fill r=%0d: got %h expected %h", name, r, obs_vec(), model_vec());
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 12 && n < 8; k++) begin
      for (int r = 0; r < 8; r++) exp[RW-1-W*r -: W] = (kind == 1) ? W'(-(8 * r + n)) : W'(8 * r + n);
      checks++;
      if ({bus.out_valid, bus.out_idx, bus.out_last, bus.out_col} !== {1'b1, 3'(n), n == 7, exp}) begin
        errors++;
        $display("FAIL %s_col%0d: got %h expected %h", name, n,
                 {bus.out_valid, bus.out_idx, bus.out_last, bus.out_col}, {1'b1, 3'(n), n == 7, exp});
      end
      n++;
      tick();
    end
    checks++;
    if (n != 8 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: got cols=%0d valid=%b expected cols=8 valid=0", name, n, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int sent, got;
    sent = 0;
    got = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60 && got < 24; k++) begin
      bus.in_valid = (sent < 24);
      bus.in_row = make_row(sent, 2);
      checks++;
      if (obs_vec() !== model_vec() || (sent < 24 && bus.in_ready !== 1'b1)) begin
        errors++;
        $display("FAIL b2b cyc=%0d: got %h expected %h", k, obs_vec(), model_vec());
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.out_idx !== 3'(got % 8)) begin
          errors++;
          $display("FAIL b2b_idx: got %0d expected %0d", bus.out_idx, got % 8);
        end
        got++;
      end
      if (sent < 24 && pending() < 2) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 24) begin
      errors++;
      $display("FAIL b2b_count: got %0d columns expected 24", got);
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] held;
    int n;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_row = make_row(k, 2);
      checks++;
      if (bus.in_ready !== 1'b1 || obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL bp_fill row=%0d: got %h expected %h", k, obs_vec(), model_vec());
      end
      tick();
    end
    bus.in_row = make_row(16, 2);
    held = col_q[0];
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_idx, bus.out_col} !== {1'b0, 1'b1, 3'd0, held}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d: got %h expected %h", k,
                 {bus.in_ready, bus.out_valid, bus.out_idx, bus.out_col}, {1'b0, 1'b1, 3'd0, held});
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && n < 16; k++) begin
      checks++;
      if (obs_vec() !== model_vec() || bus.in_ready !== (n >= 8)) begin
        errors++;
        $display("FAIL bp_drain col=%0d: got %h expected %h", n, obs_vec(), model_vec());
      end
      n++;
      tick();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL bp_timeout: got %0d columns expected 16", n);
    end
  endtask

  task automatic test_stall();
    logic [RW-1:0] held;
    int n;
    logic stalled;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bus.in_valid = 1'b1;
      bus.in_row = make_row(r, 2);
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL stall_fill r=%0d: got %h expected %h", r, obs_vec(), model_vec());
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    stalled = 1'b0;
    for (int k = 0; k < 30 && n < 8; k++) begin
      if (n == 3 && !stalled) begin
        bus.out_ready = 1'b0;
        held = col_q[0];
        for (int s = 0; s < 5; s++) begin
          checks++;
          if ({bus.out_valid, bus.out_idx, bus.out_col} !== {1'b1, 3'd3, held}) begin
            errors++;
            $display("FAIL stall_hold s=%0d: got idx=%0d col=%h expected idx=3 col=%h", s,
                     bus.out_idx, bus.out_col, held);
          end
          tick();
        end
        stalled = 1'b1;
        bus.out_ready = 1'b1;
      end
      checks++;
      if (bus.out_idx !== 3'(n) || obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL stall_drain col=%0d: got %h expected %h", n, obs_vec(), model_vec());
      end
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL stall_timeout: got %0d columns expected 8", n);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      bus.in_valid = 1'b1;
      bus.in_row = make_row(k, 2);
      bus.out_ready = (k == 8 || k == 9);
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL rstmid_fill k=%0d: got %h expected %h", k, obs_vec(), model_vec());
      end
      tick();
    end
    checks++;
    if (bus.out_idx !== 3'd2 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got idx=%0d valid=%b expected idx=2 valid=1", bus.out_idx, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs_vec() !== {1'b1, 1'b0, 3'd0, 1'b0, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL rstmid_post: got %h expected %h", obs_vec(), {1'b1, 5'd0, {RW{1'b0}}});
    end
    test_single_block(0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_row = make_row(0, 2);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d: got %h expected %h", k, obs_vec(), model_vec());
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && col_q.size() > 0; k++) begin
      checks++;
      if (obs_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_drain cyc=%0d: got %h expected %h", k, obs_vec(), model_vec());
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_end: got valid=%b expected 0", bus.out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_row = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_block(0, "single");
    test_single_block(1, "signed");
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
